knn_k_vote: RTL and testbench



---
 rtl/knn_k_vote_if.sv | 31 +++
 rtl/knn_k_vote.sv | 197 +++++++++++++++++++
 tb/tb_knn_k_vote.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/knn_k_vote_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | knn_k_vote_if : sample-in / result-out handshake bundle for knn_k_vote|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface knn_k_vote_if #(
  parameter int DIST_W  = 16,
  parameter int LABEL_W = 3
);
  logic               s_valid;
  logic               s_ready;
  logic [DIST_W-1:0]  s_dist;
  logic [LABEL_W-1:0] s_label;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [LABEL_W-1:0] m_class;
  logic [4:0]         m_votes;
  logic [4:0]         m_count;

  modport master (
    output s_valid, s_dist, s_label, s_last, m_ready,
    input  s_ready, m_valid, m_class, m_votes, m_count
  );

  modport slave (
    input  s_valid, s_dist, s_label, s_last, m_ready,
    output s_ready, m_valid, m_class, m_votes, m_count
  );
endinterface
`default_nettype wire

// File: rtl/knn_k_vote.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | knn_k_vote : streaming K-smallest selector with majority class vote  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module knn_k_vote #(
  parameter int DIST_W  = 16,
  parameter int LABEL_W = 3,
  parameter int MAX_K   = 31
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic [4:0] k_value,
  output logic            busy,
  knn_k_vote_if.slave     bus
);
  localparam int                 NCLASS       = 2**LABEL_W;
  localparam logic [4:0]         C_MAX_K      = 5'(MAX_K);
  localparam logic [LABEL_W-1:0] C_LAST_CLASS = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VOTE    = 3'd2,
    ST_ARGMAX  = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rdy_en_q;
  logic [4:0]           keff_q, keff_d;
  logic [DIST_W-1:0]    dist_q [MAX_K];
  logic [DIST_W-1:0]    dist_d [MAX_K];
  logic [LABEL_W-1:0]   lab_q  [MAX_K];
  logic [LABEL_W-1:0]   lab_d  [MAX_K];
  logic [MAX_K-1:0]     vld_q, vld_d;
  logic [4:0]           cnt_q  [NCLASS];
  logic [4:0]           cnt_d  [NCLASS];
  logic [4:0]           idx_q, idx_d;
  logic [LABEL_W-1:0]   cls_q, cls_d;
  logic [LABEL_W-1:0]   best_cls_q, best_cls_d;
  logic [4:0]           best_votes_q, best_votes_d;
  logic [4:0]           count_q, count_d;
  logic                 mvalid_q, mvalid_d;

  logic                 w_take;
  logic [4:0]           w_keff_new;
  logic [4:0]           w_keff_use;
  logic [MAX_K-1:0]     w_keep;
  logic [DIST_W-1:0]    w_ins_dist [MAX_K];
  logic [LABEL_W-1:0]   w_ins_lab  [MAX_K];
  logic [MAX_K-1:0]     w_ins_vld;

  assign bus.s_ready = rdy_en_q && (state_q == ST_IDLE || state_q == ST_COLLECT);
  assign bus.m_valid = mvalid_q;
  assign bus.m_class = best_cls_q;
  assign bus.m_votes = best_votes_q;
  assign bus.m_count = count_q;
  assign busy        = (state_q != ST_IDLE);
  assign w_take      = bus.s_valid && bus.s_ready;

  always_comb begin
    w_keff_new = k_value;
    if (k_value == 5'd0)
      w_keff_new = 5'd1;
    else if (k_value > C_MAX_K)
      w_keff_new = C_MAX_K;
  end

  assign w_keff_use = (state_q == ST_IDLE) ? w_keff_new : keff_q;

  // Valid entries form a sorted prefix, so the "keep in place" mask is a prefix too;
  // the new sample lands on the first slot outside it, the rest shift up by one.
  always_comb begin
    for (int i = 0; i < MAX_K; i++)
      w_keep[i] = vld_q[i] && (dist_q[i] <= bus.s_dist);
    w_ins_dist[0] = w_keep[0] ? dist_q[0] : bus.s_dist;
    w_ins_lab[0]  = w_keep[0] ? lab_q[0]  : bus.s_label;
    w_ins_vld[0]  = 1'b1;
    for (int i = 1; i < MAX_K; i++) begin
      if (w_keep[i]) begin
        w_ins_dist[i] = dist_q[i];
        w_ins_lab[i]  = lab_q[i];
        w_ins_vld[i]  = 1'b1;
      end else if (w_keep[i-1]) begin
        w_ins_dist[i] = bus.s_dist;
        w_ins_lab[i]  = bus.s_label;
        w_ins_vld[i]  = 1'b1;
      end else begin
        w_ins_dist[i] = dist_q[i-1];
        w_ins_lab[i]  = lab_q[i-1];
        w_ins_vld[i]  = vld_q[i-1];
      end
    end
    for (int i = 0; i < MAX_K; i++)
      if (5'(i) >= w_keff_use) w_ins_vld[i] = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    keff_d       = keff_q;
    dist_d       = dist_q;
    lab_d        = lab_q;
    vld_d        = vld_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    cls_d        = cls_q;
    best_cls_d   = best_cls_q;
    best_votes_d = best_votes_q;
    count_d      = count_q;
    mvalid_d     = mvalid_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (w_take) begin
          dist_d = w_ins_dist;
          lab_d  = w_ins_lab;
          vld_d  = w_ins_vld;
          idx_d  = 5'd0;
          if (state_q == ST_IDLE) keff_d = w_keff_new;
          state_d = bus.s_last ? ST_VOTE : ST_COLLECT;
        end
      end
      ST_VOTE: begin
        if (vld_q[idx_q]) begin
          cnt_d[lab_q[idx_q]] = cnt_q[lab_q[idx_q]] + 5'd1;
          count_d             = count_q + 5'd1;
        end
        if (idx_q == keff_q - 5'd1) begin
          cls_d   = '0;
          state_d = ST_ARGMAX;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_ARGMAX: begin
        // Strict compare: ties resolve to the lowest class index.
        if (cnt_q[cls_q] > best_votes_q) begin
          best_cls_d   = cls_q;
          best_votes_d = cnt_q[cls_q];
        end
        if (cls_q == C_LAST_CLASS)
          state_d = ST_OUT;
        else
          cls_d = cls_q + 1'b1;
      end
      ST_OUT: begin
        if (!mvalid_q) begin
          mvalid_d = 1'b1;
        end else if (bus.m_ready) begin
          mvalid_d     = 1'b0;
          vld_d        = '0;
          for (int c = 0; c < NCLASS; c++) cnt_d[c] = 5'd0;
          best_cls_d   = '0;
          best_votes_d = 5'd0;
          count_d      = 5'd0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rdy_en_q     <= 1'b0;
      keff_q       <= 5'd1;
      vld_q        <= '0;
      idx_q        <= 5'd0;
      cls_q        <= '0;
      best_cls_q   <= '0;
      best_votes_q <= 5'd0;
      count_q      <= 5'd0;
      mvalid_q     <= 1'b0;
      for (int i = 0; i < MAX_K; i++) begin
        dist_q[i] <= '0;
        lab_q[i]  <= '0;
      end
      for (int c = 0; c < NCLASS; c++) cnt_q[c] <= 5'd0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= 1'b1;
      keff_q       <= keff_d;
      dist_q       <= dist_d;
      lab_q        <= lab_d;
      vld_q        <= vld_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      cls_q        <= cls_d;
      best_cls_q   <= best_cls_d;
      best_votes_q <= best_votes_d;
      count_q      <= count_d;
      mvalid_q     <= mvalid_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_knn_k_vote.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_knn_k_vote : directed self-checking bench for knn_k_vote          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_knn_k_vote;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] k_value = 5'd0;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  knn_k_vote_if #(.DIST_W(16), .LABEL_W(3)) bus ();

  knn_k_vote #(.DIST_W(16), .LABEL_W(3), .MAX_K(31)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .k_value (k_value),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns 1 ns after the handshake edge.
  task automatic send(input logic [15:0] d, input logic [2:0] l, input logic last);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_dist  = d;
    bus.s_label = l;
    bus.s_last  = last;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [2:0] ec,
                            input logic [4:0] ev, input logic [4:0] en);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_class"}, 32'(bus.m_class), 32'(ec));
    chk({tag, "_votes"}, 32'(bus.m_votes), 32'(ev));
    chk({tag, "_count"}, 32'(bus.m_count), 32'(en));
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic scen1;
    k_value = 5'd3;
    send(16'd10, 3'd1, 1'b0);
    send(16'd5,  3'd2, 1'b0);
    send(16'd7,  3'd2, 1'b0);
    send(16'd20, 3'd1, 1'b0);
    send(16'd3,  3'd1, 1'b1);
  endtask

  initial begin
    int n;
    logic [2:0] hold_c;
    logic [4:0] hold_v, hold_n;
    bus.s_valid = 1'b0;
    bus.s_dist  = '0;
    bus.s_label = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_m_class", 32'(bus.m_class), 0);
    chk("rst_m_count", 32'(bus.m_count), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_s_ready", 32'(bus.s_ready), 1);
    @(negedge clk);

    // Basic K=3
    scen1();
    get_result("k3", 3'd2, 5'd2, 5'd3);

    // K=0 -> Keff=1
    k_value = 5'd0;
    send(16'd9, 3'd4, 1'b0);
    send(16'd2, 3'd6, 1'b1);
    get_result("k0", 3'd6, 5'd1, 5'd1);

    // K=31, 40 descending distances, labels i%8: kept i=9..39
    k_value = 5'd31;
    for (int i = 0; i < 40; i++)
      send(16'(40 - i), 3'(i % 8), (i == 39));
    get_result("k31", 3'd1, 5'd4, 5'd31);

    // Vote tie -> lower class
    k_value = 5'd4;
    send(16'd1, 3'd3, 1'b0);
    send(16'd2, 3'd5, 1'b0);
    send(16'd3, 3'd5, 1'b0);
    send(16'd4, 3'd3, 1'b1);
    get_result("vtie", 3'd3, 5'd2, 5'd4);

    // Equal distance -> earlier sample kept
    k_value = 5'd1;
    send(16'd5, 3'd2, 1'b0);
    send(16'd5, 3'd7, 1'b1);
    get_result("dtie", 3'd2, 5'd1, 5'd1);

    // Short frame
    k_value = 5'd5;
    send(16'd4, 3'd1, 1'b0);
    send(16'd8, 3'd1, 1'b1);
    get_result("short", 3'd1, 5'd2, 5'd2);

    // Latency, mid-frame K change, backpressure
    k_value = 5'd3;
    send(16'd10, 3'd1, 1'b0);
    send(16'd5,  3'd2, 1'b0);
    k_value = 5'd1;
    send(16'd7,  3'd2, 1'b0);
    send(16'd20, 3'd1, 1'b0);
    send(16'd3,  3'd1, 1'b1);
    n = 0;
    while (!bus.m_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 12);
    hold_c = bus.m_class;
    hold_v = bus.m_votes;
    hold_n = bus.m_count;
    repeat (10) @(negedge clk);
    chk("bp_m_valid", 32'(bus.m_valid), 1);
    chk("bp_s_ready", 32'(bus.s_ready), 0);
    chk("bp_busy",    32'(busy), 1);
    chk("bp_stable",  32'({bus.m_class, bus.m_votes, bus.m_count}),
                      32'({hold_c, hold_v, hold_n}));
    chk("kchg_class", 32'(bus.m_class), 2);
    chk("kchg_count", 32'(bus.m_count), 3);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    chk("rel_ready_next", 32'(bus.s_ready), 1);
    chk("rel_m_valid",    32'(bus.m_valid), 0);
    @(negedge clk);

    // Reset during VOTE, then replay
    k_value = 5'd3;
    scen1();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_m_valid", 32'(bus.m_valid), 0);
    chk("abort_busy",    32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_s_ready", 32'(bus.s_ready), 1);
    @(negedge clk);
    scen1();
    get_result("replay", 3'd2, 5'd2, 5'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
